ddr2_user_if: RTL
=================

DDR2_USER_IF -- requirements
Module: ddr2_user_if

Interface
REQ-001 SHALL have parameter NUM_BURSTS, default 256, number of BL4 bursts written then read back (8 words per burst).
REQ-002 SHALL have parameter ADDR_BASE, default 0, first app_af_addr value.
REQ-003 SHALL have parameter FIFO_DEPTH, default 64, input word FIFO depth (power of 2).
REQ-004 SHALL have port clk  in  1  sole clock; all logic rising-edge.
REQ-005 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-006 SHALL have ports phy_init_done  in  1  PHY calibrated; wr_en  in  1  din valid; din  in  32  data word; rd_en  in  1  start read-back (level).
REQ-007 SHALL have ports app_af_cmd  out  3  (000 write, 001 read); app_af_addr  out  31; app_af_wren  out  1; app_af_afull  in  1.
REQ-008 SHALL have ports app_wdf_data  out  128; app_wdf_mask_data  out  16; app_wdf_wren  out  1; app_wdf_afull  in  1.
REQ-009 SHALL have ports rd_data_valid  in  1; rd_data_fifo_out  in  128.
REQ-010 SHALL have status outputs wr_done, rd_done, ovf (1 each) and err_cnt (16).

Function
REQ-011 SHALL push din into the FIFO on every wr_en cycle; a push while full SHALL be dropped and set sticky ovf.
REQ-012 SHALL pack 4 FIFO words into one 128-bit beat, first word in bits [31:0]; 2 beats form one burst.
REQ-013 SHALL not start a burst until the FIFO holds at least 8 words; an incomplete trailing group SHALL never be issued.
REQ-014 SHALL implement FSM IDLE -> WR_B0 -> WR_B1 -> (WR_B0 | RD_CMD) -> RD_WAIT -> DONE.
REQ-015 IDLE SHALL leave only when phy_init_done=1 and 8 words are available.
REQ-016 WR_B0 SHALL, in one cycle with app_af_afull=0 and app_wdf_afull=0, assert app_af_wren (cmd 000, current addr) and app_wdf_wren (beat 0); otherwise stall with both strobes low.
REQ-017 WR_B1 SHALL assert app_wdf_wren with beat 1 when app_wdf_afull=0, then add 4 to addr.
REQ-018 After burst NUM_BURSTS-1, SHALL set wr_done, reset addr to ADDR_BASE, wait in RD_CMD for rd_en=1.
REQ-019 RD_CMD SHALL issue one read command (cmd 001) per cycle with app_af_afull=0, addr +4 each, NUM_BURSTS total, then enter RD_WAIT.
REQ-020 app_wdf_mask_data SHALL be constant 0.
REQ-021 Addr arithmetic SHALL be 31-bit modulo 2^31; wrap SHALL not be flagged.
REQ-022 RD_WAIT SHALL count rd_data_valid beats; at 2*NUM_BURSTS beats SHALL set rd_done and enter DONE.
REQ-023 DONE SHALL hold all strobes low until reset.
REQ-024 wr_en during read phase SHALL still fill the FIFO (ovf rules apply) but SHALL issue no writes.

Reset
REQ-025 reset SHALL return FSM to IDLE, empty FIFO, addr=ADDR_BASE, all strobes, wr_done, rd_done, ovf, err_cnt to 0, app_af_cmd=000, app_wdf_data=0.
REQ-026 reset mid-burst SHALL abandon the burst with no further strobes from the next cycle.

Configuration
REQ-027 With DDR2_RD_CHK_EN defined, SHALL compare each valid beat to expected {w+3,w+2,w+1,w} (w starts at 0, +4 per beat) and increment err_cnt per mismatching beat, saturating at 16'hFFFF.
REQ-028 Without DDR2_RD_CHK_EN, err_cnt SHALL be constant 0 and rd_data_fifo_out SHALL be unused; beat counting SHALL remain.

Structure
REQ-029 Shared package ddr2_pkg SHALL hold command codes CMD_WR/CMD_RD, FSM state enum, APP_DATA_W=128, APP_ADDR_W=31.
REQ-030 Input buffer SHALL be sub-module sync_fifo (32-bit, FIFO_DEPTH, full/empty/count).

Verification
REQ-031 NUM_BURSTS=2, din 0..15 on consecutive wr_en, afull low -> 2 write cmds at addr 0,4; beats 0x00000003_00000002_00000001_00000000 .. 0x0000000F_0000000E_0000000D_0000000C; wr_done=1.
REQ-032 app_wdf_afull high 5 cycles during WR_B1 -> beat 1 delayed exactly 5 cycles, no duplicate strobes.
REQ-033 FIFO_DEPTH=8, phy_init_done=0, 9 wr_en words -> ovf=1, FIFO count 8, no commands.
REQ-034 rd_en=1 after wr_done, return matching 4 beats -> 2 read cmds at 0,4, rd_done=1, err_cnt=0; flip bit 0 of beat 2 -> err_cnt=1 (DDR2_RD_CHK_EN).
REQ-035 reset asserted in WR_B1 -> next cycle all strobes 0, state IDLE, addr=ADDR_BASE.

Source files
------------

// File: rtl/ddr2_pkg.sv
// Shared definitions for the DDR2 user-interface write/read-back block:
// command codes, FSM states, bus widths and the read-back data pattern.
package ddr2_pkg;

  localparam int APP_DATA_W      = 128;
  localparam int APP_ADDR_W      = 31;
  localparam int APP_MASK_W      = 16;
  localparam int WORD_W          = 32;
  localparam int WORDS_PER_BEAT  = 4;
  localparam int WORDS_PER_BURST = 8;

  localparam logic [2:0] CMD_WR = 3'b000;
  localparam logic [2:0] CMD_RD = 3'b001;

  typedef enum logic [2:0] {
    IDLE,
    WR_B0,
    WR_B1,
    RD_CMD,
    RD_WAIT,
    DONE
  } state_t;

  // Read-back beat for a pattern whose lowest word is w: {w+3, w+2, w+1, w}.
  function automatic logic [APP_DATA_W-1:0] expected_beat(input logic [WORD_W-1:0] w);
    return {w + 32'd3, w + 32'd2, w + 32'd1, w};
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock word FIFO: one word pushed per cycle, GROUP words popped at
// once through a parallel window (oldest word in the lowest slice).
module sync_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 64,
  parameter int GROUP  = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      wr_en,
  input  logic [DATA_W-1:0]         din,
  input  logic                      pop,
  output logic [GROUP*DATA_W-1:0]   group_data,
  output logic                      full,
  output logic                      empty,
  output logic [$clog2(DEPTH):0]    count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              push;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign push  = wr_en && !full;

  // NOTE: the storage array has no reset; pointers and count alone decide which entries are valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(GROUP);
      count <= count + CW'(push) - (pop ? CW'(GROUP) : CW'(0));
    end
  end

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    group_data = '0;
    for (int g = 0; g < GROUP; g++) begin
      group_data[g*DATA_W +: DATA_W] = mem[rd_ptr + AW'(g)];
    end
  end

endmodule

// File: rtl/ddr2_user_if.sv
// Writes NUM_BURSTS BL4 bursts from a word FIFO to a DDR2 controller user
// interface, then reads them back. Optional beat checker: DDR2_RD_CHK_EN.
module ddr2_user_if
  import ddr2_pkg::*;
#(
  parameter int                    NUM_BURSTS = 256,
  parameter logic [APP_ADDR_W-1:0] ADDR_BASE  = '0,
  parameter int                    FIFO_DEPTH = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  phy_init_done,
  input  logic                  wr_en,
  input  logic [WORD_W-1:0]     din,
  input  logic                  rd_en,
  output logic [2:0]            app_af_cmd,
  output logic [APP_ADDR_W-1:0] app_af_addr,
  output logic                  app_af_wren,
  input  logic                  app_af_afull,
  output logic [APP_DATA_W-1:0] app_wdf_data,
  output logic [APP_MASK_W-1:0] app_wdf_mask_data,
  output logic                  app_wdf_wren,
  input  logic                  app_wdf_afull,
  input  logic                  rd_data_valid,
  input  logic [APP_DATA_W-1:0] rd_data_fifo_out,
  output logic                  wr_done,
  output logic                  rd_done,
  output logic                  ovf,
  output logic [15:0]           err_cnt
);

  localparam int FCW = $clog2(FIFO_DEPTH) + 1;
  localparam int BCW = $clog2(2 * NUM_BURSTS + 1);
  localparam logic [BCW-1:0] LAST_BURST  = BCW'(NUM_BURSTS - 1);
  localparam logic [BCW-1:0] TOTAL_BEATS = BCW'(2 * NUM_BURSTS);

  state_t                state;
  state_t                state_nxt;
  logic [APP_ADDR_W-1:0] addr;
  logic [BCW-1:0]        burst_cnt;
  logic [BCW-1:0]        rd_cmd_cnt;
  logic [BCW-1:0]        beat_cnt;
  logic [BCW-1:0]        beat_cnt_nxt;

  logic [FCW-1:0]        fifo_count;
  logic [APP_DATA_W-1:0] fifo_group;
  logic                  fifo_full;
  logic                  fifo_empty_unused;
  logic                  fifo_pop;

  logic group_ready;
  logic wr_b0_go;
  logic wr_b1_go;
  logic rd_go;
  logic beat_seen;
  logic last_burst;
  logic last_rd;

  sync_fifo #(
    .DATA_W (WORD_W),
    .DEPTH  (FIFO_DEPTH),
    .GROUP  (WORDS_PER_BEAT)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .wr_en      (wr_en),
    .din        (din),
    .pop        (fifo_pop),
    .group_data (fifo_group),
    .full       (fifo_full),
    .empty      (fifo_empty_unused),
    .count      (fifo_count)
  );

  // A burst only starts with a full 8-word group buffered, so beat 1 never waits on data.
  assign group_ready  = (fifo_count >= FCW'(WORDS_PER_BURST));
  assign wr_b0_go     = (state == WR_B0) && group_ready && !app_af_afull && !app_wdf_afull;
  assign wr_b1_go     = (state == WR_B1) && !app_wdf_afull;
  assign rd_go        = (state == RD_CMD) && rd_en && !app_af_afull;
  assign beat_seen    = rd_data_valid && ((state == RD_CMD) || (state == RD_WAIT));
  assign beat_cnt_nxt = beat_cnt + BCW'(beat_seen);
  assign last_burst   = (burst_cnt == LAST_BURST);
  assign last_rd      = (rd_cmd_cnt == LAST_BURST);
  assign fifo_pop     = wr_b0_go || wr_b1_go;

  assign app_af_addr       = addr;
  assign app_wdf_mask_data = '0;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (phy_init_done && group_ready) state_nxt = WR_B0;
      WR_B0:   if (wr_b0_go) state_nxt = WR_B1;
      WR_B1:   if (wr_b1_go) state_nxt = last_burst ? RD_CMD : WR_B0;
      RD_CMD:  if (rd_go && last_rd) state_nxt = RD_WAIT;
      RD_WAIT: if (beat_cnt_nxt == TOTAL_BEATS) state_nxt = DONE;
      DONE:    state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  // Strobes are qualified by this cycle's afull flags, so a stall never leaves a strobe behind.
  always_comb begin
    app_af_wren  = 1'b0;
    app_wdf_wren = 1'b0;
    app_af_cmd   = CMD_WR;
    app_wdf_data = '0;
    unique case (state)
      WR_B0: begin
        if (wr_b0_go) begin
          app_af_wren  = 1'b1;
          app_wdf_wren = 1'b1;
          app_wdf_data = fifo_group;
        end
      end
      WR_B1: begin
        if (wr_b1_go) begin
          app_wdf_wren = 1'b1;
          app_wdf_data = fifo_group;
        end
      end
      RD_CMD: begin
        app_af_cmd = CMD_RD;
        if (rd_go) app_af_wren = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      addr       <= ADDR_BASE;
      burst_cnt  <= '0;
      rd_cmd_cnt <= '0;
      beat_cnt   <= '0;
      wr_done    <= 1'b0;
      rd_done    <= 1'b0;
      ovf        <= 1'b0;
    end else begin
      if (wr_en && fifo_full) ovf <= 1'b1;
      if (wr_b1_go) begin
        burst_cnt <= burst_cnt + BCW'(1);
        if (last_burst) begin
          addr    <= ADDR_BASE;
          wr_done <= 1'b1;
        end else begin
          addr <= addr + APP_ADDR_W'(4);
        end
      end
      if (rd_go) begin
        addr       <= addr + APP_ADDR_W'(4);
        rd_cmd_cnt <= rd_cmd_cnt + BCW'(1);
      end
      if (beat_seen) beat_cnt <= beat_cnt_nxt;
      if ((state == RD_WAIT) && (beat_cnt_nxt == TOTAL_BEATS)) rd_done <= 1'b1;
    end
  end

`ifdef DDR2_RD_CHK_EN
  logic [WORD_W-1:0] exp_word;

  always_ff @(posedge clk) begin
    if (reset) begin
      exp_word <= '0;
      err_cnt  <= '0;
    end else if (beat_seen) begin
      exp_word <= exp_word + WORD_W'(WORDS_PER_BEAT);
      if ((rd_data_fifo_out != expected_beat(exp_word)) && (err_cnt != 16'hFFFF))
        err_cnt <= err_cnt + 16'd1;
    end
  end
`else
  logic unused_rd_data;

  assign err_cnt        = '0;
  assign unused_rd_data = ^rd_data_fifo_out;
`endif

endmodule
